// File: rtl/rr_grant_scheduler_if.sv
// rr_grant_scheduler_if
//   Request/grant bundle between a set of requesters and the round-robin
//   grant scheduler that owns the shared output/strobe channel.
//
//   Signals:
//     enable    requester side -> scheduler, allows new grants
//     req       requester side -> scheduler, level request per requester
//     done      requester side -> scheduler, one-cycle completion pulse
//     gnt       scheduler -> requester side, one-hot grant (zero when idle)
//     gnt_valid scheduler -> requester side, OR of gnt
//     gnt_id    scheduler -> requester side, index of granted requester
//     timeout   scheduler -> requester side, forced-release pulse
//     busy      scheduler -> requester side, grant or release in progress
//
//   Modports:
//     master  requester side (drives enable/req/done)
//     slave   scheduler side (drives the grant outputs)

interface rr_grant_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic            enable;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;
  logic            timeout;
  logic            busy;

  modport master (
    output enable,
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout,
    input  busy
  );

  modport slave (
    input  enable,
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout,
    output busy
  );

endinterface

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Shares one controlled resource among NREQ requesters. One exclusive
//   grant at a time, each grant bounded by a hold timer, with a one-cycle
//   release gap before the next arbitration. All outputs are registered.
//
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset
//     bus      rr_grant_scheduler_if.slave
//                in : enable, req[NREQ], done[NREQ]
//                out: gnt[NREQ], gnt_valid, gnt_id[IDW], timeout, busy
//
//   Parameters:
//     NREQ  number of requesters (power of 2, 2..8)
//     IDW   log2(NREQ)
//     TMAX  last timer value of a grant before forced release (1..2^CW-1)
//     CW    hold-timer width
//
//   Build option:
//     RR_GRANT_FIXED_PRIO_EN  when defined, arbitration is fixed priority
//                             (lowest set index wins) and the round-robin
//                             pointer is not built. Timer, release gap and
//                             timeout behave the same in both builds.

module rr_grant_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMAX = 15,
  parameter int CW   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  rr_grant_scheduler_if.slave   bus
);

  // state   | meaning
  // --------+---------------------------------------------------------
  // IDLE    | no grant; arbitrate when enable=1 and any req is set
  // GRANT   | one requester owns the resource; hold timer running
  // RELEASE | one-cycle gap with gnt=0 before returning to IDLE

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;

  // Hold timer runs as a down-counter: loaded with TMAX at grant time and
  // reaching zero on the cycle the elapsed-cycle count equals TMAX.
  logic [CW-1:0]   hold_q, hold_d;
  logic            hold_tc;

  logic [NREQ-1:0] req_clean;
  logic            sel_found;
  logic [IDW-1:0]  sel_idx;

  logic            own_req;
  logic            own_done;
  logic            release_now;

  // Unknown request bits must never win arbitration.
  always_comb begin
    req_clean = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_clean[i] = (bus.req[i] === 1'b1);
    end
  end

`ifdef RR_GRANT_FIXED_PRIO_EN

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_clean[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(i);
      end
    end
  end

`else

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] cand;

  // Scan ptr, ptr+1, ... descending in offset so the smallest offset from
  // ptr wins. NREQ is a power of two, so IDW-bit wrap is the modulo.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = ptr_q + IDW'(off);
      if (req_clean[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // The requester that just released becomes lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_GRANT && release_now) begin
      ptr_d = gnt_id_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  assign own_req     = req_clean[gnt_id_q];
  assign own_done    = (bus.done[gnt_id_q] === 1'b1);
  assign hold_tc     = (hold_q == '0);
  assign release_now = own_done || !own_req || hold_tc;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    hold_d      = hold_q;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable && sel_found) begin
          state_d          = ST_GRANT;
          gnt_d            = '0;
          gnt_d[sel_idx]   = 1'b1;
          gnt_id_d         = sel_idx;
          hold_d           = CW'(TMAX);
        end
      end

      ST_GRANT: begin
        if (release_now) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          // done or a dropped request takes precedence over the timer
          timeout_d = hold_tc && !own_done && own_req;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    gnt_valid_d = |gnt_d;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;

endmodule
